// File: rtl/ctrl_uop_sequencer.sv
// LC-3b decode/control sequencer: expands instructions into control-word micro-ops
// and buffers them in a small FIFO ahead of the ID/EX stage.
package lc3b_types;
    typedef enum logic [2:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;

    typedef enum logic [3:0] {
        op_br, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
        op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_aluop  aluop;
        logic       alumux2_sel;
        logic [2:0] alumux8_sel;
        logic [1:0] wbmux;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_byte_enable;
        logic       storemux_sel;
    } lc3b_control_word;
endpackage

module ctrl_uop_sequencer
    import lc3b_types::*;
#(
    parameter int DEPTH           = 4,
    parameter bit ENABLE_INDIRECT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic [15:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output lc3b_control_word out_ctrl,
    output logic [15:0]      out_pc,
    output logic             out_uop,
    output logic             out_last,
    output logic             out_illegal
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        lc3b_control_word ctrl;
        logic [15:0]      pc;
        logic             uop;
        logic             last;
        logic             illegal;
    } uop_t;

    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

    state_t           state, state_nxt;
    logic [15:0]      h_instr, h_pc;
    uop_t             fifo_mem [DEPTH];
    uop_t             h_uop, head;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             h_valid, push, pop, accept;

    function automatic uop_t decode(input logic [15:0] instr, input logic [15:0] pc,
                                    input logic idx);
        uop_t u;
        u                      = '0;
        u.pc                   = pc;
        u.uop                  = idx;
        u.last                 = 1'b1;
        u.ctrl.opcode          = lc3b_opcode'(instr[15:12]);
        u.ctrl.aluop           = alu_add;
        u.ctrl.mem_byte_enable = 2'b11;
        case (u.ctrl.opcode)
            op_add, op_and: begin
                u.ctrl.aluop        = (u.ctrl.opcode == op_and) ? alu_and : alu_add;
                u.ctrl.alumux8_sel  = instr[5] ? 3'b001 : 3'b000;
                u.ctrl.wbmux        = 2'b10;
                u.ctrl.load_regfile = 1'b1;
                u.ctrl.load_cc      = 1'b1;
            end
            op_not: begin
                u.ctrl.aluop        = alu_not;
                u.ctrl.wbmux        = 2'b10;
                u.ctrl.load_regfile = 1'b1;
                u.ctrl.load_cc      = 1'b1;
            end
            op_br: begin
                u.ctrl.alumux2_sel = 1'b1;
                u.ctrl.alumux8_sel = 3'b011;
            end
            op_ldr: begin
                u.ctrl.alumux8_sel  = 3'b110;
                u.ctrl.mem_read     = 1'b1;
                u.ctrl.wbmux        = 2'b01;
                u.ctrl.load_regfile = 1'b1;
                u.ctrl.load_cc      = 1'b1;
            end
            op_str: begin
                u.ctrl.alumux8_sel  = 3'b110;
                u.ctrl.mem_write    = 1'b1;
                u.ctrl.storemux_sel = 1'b1;
            end
            op_ldi, op_sti: begin
                if (ENABLE_INDIRECT) begin
                    if (!idx) begin
                        u.ctrl.alumux8_sel = 3'b110;
                        u.ctrl.mem_read    = 1'b1;
                        u.last             = 1'b0;
                    end else begin
                        // second uop uses the MDR (the fetched pointer) as its address
                        u.ctrl.alumux8_sel = 3'b111;
                        if (u.ctrl.opcode == op_ldi) begin
                            u.ctrl.mem_read     = 1'b1;
                            u.ctrl.wbmux        = 2'b01;
                            u.ctrl.load_regfile = 1'b1;
                            u.ctrl.load_cc      = 1'b1;
                        end else begin
                            u.ctrl.mem_write    = 1'b1;
                            u.ctrl.storemux_sel = 1'b1;
                        end
                    end
                end else begin
                    u.ctrl        = '0;
                    u.ctrl.opcode = lc3b_opcode'(instr[15:12]);
                    u.illegal     = 1'b1;
                end
            end
            default: begin
                u.ctrl        = '0;
                u.ctrl.opcode = lc3b_opcode'(instr[15:12]);
                u.illegal     = 1'b1;
            end
        endcase
        return u;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign h_valid   = (state != IDLE);
    assign h_uop     = decode(h_instr, h_pc, state == HOLD1);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = h_valid && !flush && ((count != CNT_W'(DEPTH)) || pop);
    assign in_ready  = !flush && (!h_valid || (push && h_uop.last));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (accept) state_nxt = HOLD0;
            HOLD0, HOLD1: if (push) state_nxt = h_uop.last ? (accept ? HOLD0 : IDLE) : HOLD1;
            default:      state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            h_instr <= in_instr;
            h_pc    <= in_pc;
        end
    end

    // FIFO bookkeeping; storage itself is never reset, only the pointers/count
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= h_uop;
    end

    assign head        = fifo_mem[rd_ptr];
    assign out_ctrl    = out_valid ? head.ctrl : '0;
    assign out_pc      = out_valid ? head.pc : '0;
    assign out_uop     = out_valid && head.uop;
    assign out_last    = out_valid && head.last;
    assign out_illegal = out_valid && head.illegal;
endmodule

// File: tb/tb_ctrl_uop_sequencer.sv
// Randomized + directed bench for ctrl_uop_sequencer against a transaction-level uop queue model.
module tb_ctrl_uop_sequencer;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0]      in_instr, in_pc, out_pc;
    lc3b_control_word out_ctrl;
    logic             out_uop, out_last, out_illegal;

    logic             ni_in_valid, ni_in_ready, ni_out_valid;
    logic [15:0]      ni_instr, ni_pc, ni_out_pc;
    lc3b_control_word ni_out_ctrl;
    logic             ni_out_uop, ni_out_last, ni_out_illegal;

    ctrl_uop_sequencer #(.DEPTH(4), .ENABLE_INDIRECT(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc),
        .out_uop(out_uop), .out_last(out_last), .out_illegal(out_illegal)
    );

    ctrl_uop_sequencer #(.DEPTH(2), .ENABLE_INDIRECT(1'b0)) dut_ni (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(ni_in_valid), .in_ready(ni_in_ready), .in_instr(ni_instr), .in_pc(ni_pc),
        .out_valid(ni_out_valid), .out_ready(1'b1), .out_ctrl(ni_out_ctrl), .out_pc(ni_out_pc),
        .out_uop(ni_out_uop), .out_last(ni_out_last), .out_illegal(ni_out_illegal)
    );

    typedef struct packed {
        lc3b_control_word ctrl;
        logic [15:0]      pc;
        logic             uop;
        logic             last;
        logic             illegal;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0, n_pops = 0;
    logic last_acc;

    logic             s_in_ready, s_out_valid, s_out_uop, s_out_last, s_out_illegal;
    logic [15:0]      s_out_pc;
    lc3b_control_word s_out_ctrl;
    logic             ni_s_valid, ni_s_last, ni_s_illegal;
    lc3b_control_word ni_s_ctrl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Expected uop list for one instruction, straight from the opcode table
    function automatic exp_t ref_uop(input logic [15:0] instr, input logic [15:0] pc,
                                     input logic idx, input bit ei);
        exp_t       e;
        logic [3:0] op;
        bit         ind, legal;
        op    = instr[15:12];
        ind   = ei && (op == 4'hA || op == 4'hB);
        legal = ind || op inside {4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9};
        e = '0;
        e.pc = pc;
        e.uop = idx;
        e.ctrl.opcode = lc3b_opcode'(op);
        e.last = !(ind && !idx);
        if (!legal) begin
            e.illegal = 1'b1;
            return e;
        end
        e.ctrl.mem_byte_enable = 2'b11;
        if (op == 4'h1 || op == 4'h5) begin
            if (op == 4'h5) e.ctrl.aluop = alu_and;
            e.ctrl.alumux8_sel = {2'b00, instr[5]};
            e.ctrl.wbmux = 2'b10;
            {e.ctrl.load_regfile, e.ctrl.load_cc} = 2'b11;
        end else if (op == 4'h9) begin
            e.ctrl.aluop = alu_not;
            e.ctrl.wbmux = 2'b10;
            {e.ctrl.load_regfile, e.ctrl.load_cc} = 2'b11;
        end else if (op == 4'h0) begin
            e.ctrl.alumux2_sel = 1'b1;
            e.ctrl.alumux8_sel = 3'd3;
        end else if (op == 4'h6 || (ind && idx && op == 4'hA)) begin
            e.ctrl.alumux8_sel = (op == 4'h6) ? 3'd6 : 3'd7;
            e.ctrl.mem_read = 1'b1;
            e.ctrl.wbmux = 2'b01;
            {e.ctrl.load_regfile, e.ctrl.load_cc} = 2'b11;
        end else if (op == 4'h7 || (ind && idx)) begin
            e.ctrl.alumux8_sel = (op == 4'h7) ? 3'd6 : 3'd7;
            e.ctrl.mem_write = 1'b1;
            e.ctrl.storemux_sel = 1'b1;
        end else begin
            e.ctrl.alumux8_sel = 3'd6;
            e.ctrl.mem_read = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_in_ready = in_ready;   s_out_valid = out_valid; s_out_ctrl = out_ctrl;
        s_out_pc = out_pc;       s_out_uop = out_uop;     s_out_last = out_last;
        s_out_illegal = out_illegal;
        ni_s_valid = ni_out_valid; ni_s_last = ni_out_last;
        ni_s_illegal = ni_out_illegal; ni_s_ctrl = ni_out_ctrl;
        last_acc = 1'b0;
        if (reset) q.delete();
        else begin
            if (q.size() == 0) chk("idle_out_valid", 32'(s_out_valid), 32'd0);
            if (s_out_valid && out_ready && q.size() != 0) begin
                n_pops++;
                e = q.pop_front();
                chk("pop_ctrl", 32'(s_out_ctrl), 32'(e.ctrl));
                chk("pop_pc", 32'(s_out_pc), 32'(e.pc));
                chk("pop_uop", 32'(s_out_uop), 32'(e.uop));
                chk("pop_last", 32'(s_out_last), 32'(e.last));
                chk("pop_illegal", 32'(s_out_illegal), 32'(e.illegal));
            end
            if (flush) begin
                chk("flush_in_ready", 32'(s_in_ready), 32'd0);
                q.delete();
            end else if (in_valid && s_in_ready) begin
                last_acc = 1'b1;
                q.push_back(ref_uop(in_instr, in_pc, 1'b0, 1'b1));
                if (!ref_uop(in_instr, in_pc, 1'b0, 1'b1).last)
                    q.push_back(ref_uop(in_instr, in_pc, 1'b1, 1'b1));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        lc3b_control_word cw;
        int acc, pops0;
        reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
        ni_in_valid = 0; ni_instr = 0; ni_pc = 0;
        @(posedge clk); #1;
        tick(); tick();
        reset = 0;
        tick();
        chk("rst_in_ready", 32'(s_in_ready), 32'd1);
        chk("rst_out_valid", 32'(s_out_valid), 32'd0);
        chk("rst_out_ctrl", 32'(s_out_ctrl), 32'd0);
        chk("rst_out_misc", {s_out_pc, 13'd0, s_out_uop, s_out_last, s_out_illegal}, 32'd0);

        // ADD R1,R2,#3: visible two cycles after acceptance
        out_ready = 1; in_instr = 16'h12A3; in_pc = 16'h3000; in_valid = 1;
        tick();
        chk("add_accept", 32'(s_in_ready), 32'd1);
        in_valid = 0;
        tick();
        chk("add_n1_valid", 32'(s_out_valid), 32'd0);
        tick();
        chk("add_n2_valid", 32'(s_out_valid), 32'd1);
        chk("add_mux8", 32'(s_out_ctrl.alumux8_sel), 32'd1);
        chk("add_pc", 32'(s_out_pc), 32'h3000);

        // LDI: two back-to-back uops with one stalled accept between
        in_instr = 16'hA242; in_pc = 16'h3002; in_valid = 1;
        tick();
        chk("ldi_accept", 32'(s_in_ready), 32'd1);
        in_instr = 16'h1042; in_pc = 16'h3004;
        tick();
        chk("ldi_gap", 32'(s_in_ready), 32'd0);
        tick();
        chk("ldi_resume", 32'(s_in_ready), 32'd1);
        chk("ldi_u0", {s_out_valid, s_out_uop, s_out_last, s_out_ctrl.mem_read}, 32'b1001);
        chk("ldi_u0_mux", 32'(s_out_ctrl.alumux8_sel), 32'd6);
        in_valid = 0;
        tick();
        chk("ldi_u1", {s_out_valid, s_out_uop, s_out_last, s_out_ctrl.load_regfile}, 32'b1111);
        chk("ldi_u1_mux", 32'(s_out_ctrl.alumux8_sel), 32'd7);
        tick(); tick();

        // Fill with out_ready low, then drain across pointer wrap
        out_ready = 0; acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (acc < 6);
            in_instr = {4'h1, 12'($urandom)}; in_pc = 16'h4000 + 16'(2 * acc);
            tick();
            if (last_acc) acc++;
        end
        chk("fill_accepted", 32'(acc), 32'd5);
        chk("fill_in_ready", 32'(s_in_ready), 32'd0);
        chk("fill_valid", 32'(s_out_valid), 32'd1);
        out_ready = 1; pops0 = n_pops;
        for (int c = 0; c < 40 && (q.size() != 0 || acc < 6); c++) begin
            in_valid = (acc < 6);
            in_instr = {4'h1, 12'($urandom)}; in_pc = 16'h4000 + 16'(2 * acc);
            tick();
            if (last_acc) acc++;
        end
        in_valid = 0;
        chk("fill_pops", 32'(n_pops - pops0), 32'd6);
        chk("fill_drained", 32'(q.size()), 32'd0);

        // STI flushed while its second uop is held
        in_instr = 16'hB242; in_pc = 16'h5000; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        flush = 1; pops0 = n_pops;
        tick();
        chk("fl_uop0", {s_out_valid, s_out_uop}, 32'b10);
        flush = 0;
        tick();
        chk("fl_empty", 32'(s_out_valid), 32'd0);
        chk("fl_ready", 32'(s_in_ready), 32'd1);
        tick();
        chk("fl_pops", 32'(n_pops - pops0), 32'd1);

        // Unknown opcode on the main instance
        in_instr = 16'hD123; in_pc = 16'h6000; in_valid = 1;
        tick();
        in_valid = 0;
        tick(); tick();
        cw = '0; cw.opcode = op_shf;
        chk("ill_flags", {s_out_valid, s_out_illegal, s_out_last}, 32'b111);
        chk("ill_ctrl", 32'(s_out_ctrl), 32'(cw));

        // STI with indirect ops disabled
        ni_instr = 16'hB242; ni_pc = 16'h6100; ni_in_valid = 1;
        tick();
        ni_in_valid = 0;
        tick(); tick();
        cw = '0; cw.opcode = op_sti;
        chk("ni_flags", {ni_s_valid, ni_s_illegal, ni_s_last}, 32'b111);
        chk("ni_ctrl", 32'(ni_s_ctrl), 32'(cw));
        tick();
        chk("ni_single", 32'(ni_s_valid), 32'd0);

        // Random traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 10) < 7;
            in_instr = 16'($urandom);
            in_pc = 16'($urandom) & 16'hFFFE;
            out_ready = ($urandom % 10) < 6;
            flush = ($urandom % 30) == 0;
            tick();
        end
        flush = 0; in_valid = 0; out_ready = 1;
        for (int c = 0; c < 20 && q.size() != 0; c++) tick();
        chk("rnd_drained", 32'(q.size()), 32'd0);
        tick();

        // Reset with 3 uops buffered and an LDI held in its second uop
        out_ready = 0; in_valid = 1; in_instr = 16'h1042; in_pc = 16'h7000;
        tick();
        in_pc = 16'h7002;
        tick();
        in_instr = 16'hA242; in_pc = 16'h7004;
        tick();
        in_valid = 0;
        tick();
        reset = 1;
        tick();
        chk("rs_pre_valid", 32'(s_out_valid), 32'd1);
        reset = 0;
        tick();
        chk("rs_valid", 32'(s_out_valid), 32'd0);
        chk("rs_ready", 32'(s_in_ready), 32'd1);
        chk("rs_outs", {s_out_pc, 13'd0, s_out_uop, s_out_last, s_out_illegal}, 32'd0);
        chk("rs_ctrl", 32'(s_out_ctrl), 32'd0);
        tick(); tick();
        chk("rs_stay_empty", 32'(s_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
